branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Execute-side partner of the BTB: holds each fetch-stage target prediction in a
//  small in-order queue, checks it against the branch outcome resolved in execute,
//  drives the BTB write port (Br_x/PC_x/alu_out), and on mispredict issues a
//  registered fetch redirect plus a multi-cycle pipeline flush. Keeps hit/miss stats.
// PARAMETERS
//  AWIDTH     32  address/target width
//  QDEPTH     4   prediction queue entries (power of 2, >=2)
//  FLUSH_CYC  2   cycles flush stays high per mispredict (>=1)
//  CWIDTH     16  statistics counter width
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       asynchronous, active-low reset
//  pred_valid     in   1       fetch pushes prediction for a fetched branch
//  pred_pc        in   AWIDTH  PC of that branch (PC_f)
//  pred_target    in   AWIDTH  target fetch used (BrTarget; PC+4 on BTB miss)
//  pred_ready     out  1       queue can accept a push this cycle
//  res_valid      in   1       execute resolved the oldest in-flight branch
//  res_pc         in   AWIDTH  PC of resolved branch (PC_x)
//  res_taken      in   1       branch condition true
//  res_target     in   AWIDTH  computed target (alu_out)
//  upd_en         out  1       BTB write enable (to Br_x)
//  upd_pc         out  AWIDTH  BTB write tag/index (to PC_x)
//  upd_target     out  AWIDTH  BTB write data (to alu_out)
//  redirect_valid out  1       fetch must load redirect_pc next cycle
//  redirect_pc    out  AWIDTH  correct next PC
//  flush          out  1       kill wrong-path instructions in F/D
//  branch_cnt     out  CWIDTH  resolved branches (saturating)
//  mispred_cnt    out  CWIDTH  mispredicted branches (saturating)
//  err_seq        out  1       sticky: underflow, overflow, or res_pc != head pc
// BEHAVIOUR
//  - Reset (rst low, async): queue empty, FSM IDLE, all outputs 0, counters 0.
//  - Queue: circular, log2(QDEPTH)+1-bit ptrs; full when ptrs differ only in MSB.
//    pred_ready = !full && state==IDLE. Push when pred_valid && pred_ready.
//    Push while full: dropped, err_seq set. Push+pop same cycle legal when not full.
//  - Resolve (IDLE, res_valid): pop head. actual = res_taken ? res_target : res_pc+4
//    (mod 2^AWIDTH). mispredict = head.pred_target != actual.
//    Empty queue: no pop, err_seq set, no outputs. head.pc != res_pc: err_seq set,
//    still compared and popped.
//  - All outputs registered: resolve in cycle N -> outputs visible N+1, 1-cycle pulses.
//    upd_en=1 iff res_taken; upd_pc=res_pc, upd_target=res_target.
//    branch_cnt +1 every accepted resolve; mispred_cnt +1 on mispredict; both hold at max.
//  - FSM: IDLE -> FLUSH on mispredict. On that edge: queue cleared (younger entries
//    are wrong-path), redirect_valid=1, redirect_pc=actual, flush=1 for N+1.
//    FLUSH: flush=1, redirect_valid=0 after first cycle; counts FLUSH_CYC cycles
//    total of flush, then -> IDLE. res_valid and pred_valid ignored in FLUSH
//    (no pop, no push, no err_seq).
//  - Correct prediction: state stays IDLE, no redirect, no flush; upd_en still per res_taken.
//  - Async reset mid-FLUSH: immediately IDLE, flush/redirect low, queue empty.
// TESTING
//  1 Push pc=0x100 tgt=0x104; resolve pc=0x100 taken=0 -> N+1: no redirect, upd_en=0,
//    branch_cnt=1, mispred_cnt=0.
//  2 Push pc=0x200 tgt=0x204, push 0x208; resolve 0x200 taken=1 tgt=0x300 -> N+1:
//    redirect_valid=1 pc=0x300, upd_en=1 pc=0x200 tgt=0x300; flush high exactly 2 cycles;
//    queue empty after, pred_ready low during flush.
//  3 Fill QDEPTH=4 entries -> pred_ready=0; 5th push dropped, err_seq=1; same-cycle
//    push+pop at 3 entries keeps count 3.
//  4 res_valid with empty queue -> err_seq=1, counters unchanged, no upd_en.
//  5 Assert rst low during FLUSH cycle 1 -> flush=0, redirect_valid=0, counters 0
//    before next clock edge.
//  6 Preload mispred_cnt near max (CWIDTH=4): 16 mispredicts -> holds at 15, no wrap.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch-stage target predictions in order, compares
// each against the branch outcome resolved in execute, drives the BTB write port,
// and on a mispredict issues a registered fetch redirect plus a multi-cycle flush.
module branch_resolve_unit #(
    parameter int AWIDTH    = 32,
    parameter int QDEPTH    = 4,
    parameter int FLUSH_CYC = 2,
    parameter int CWIDTH    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic [AWIDTH-1:0] pred_pc,
    input  logic [AWIDTH-1:0] pred_target,
    output logic              pred_ready,
    input  logic              res_valid,
    input  logic [AWIDTH-1:0] res_pc,
    input  logic              res_taken,
    input  logic [AWIDTH-1:0] res_target,
    output logic              upd_en,
    output logic [AWIDTH-1:0] upd_pc,
    output logic [AWIDTH-1:0] upd_target,
    output logic              redirect_valid,
    output logic [AWIDTH-1:0] redirect_pc,
    output logic              flush,
    output logic [CWIDTH-1:0] branch_cnt,
    output logic [CWIDTH-1:0] mispred_cnt,
    output logic              err_seq
);

    localparam int IW  = $clog2(QDEPTH);
    localparam int PW  = IW + 1;
    localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state, state_d;
    logic [FCW-1:0]    fcnt, fcnt_d;

    logic [AWIDTH-1:0] q_pc  [QDEPTH];
    logic [AWIDTH-1:0] q_tgt [QDEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;

    logic              in_idle, full, empty, push, pop, mispredict, seq_err;
    logic [AWIDTH-1:0] head_pc, head_tgt, actual;

    function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_idle  = (state == IDLE);
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
    assign pred_ready = !full && in_idle;

    assign push     = pred_valid && pred_ready;
    assign pop      = in_idle && res_valid && !empty;
    assign head_pc  = q_pc[rd_ptr[IW-1:0]];
    assign head_tgt = q_tgt[rd_ptr[IW-1:0]];

    // Fall-through address wraps naturally at AWIDTH bits.
    assign actual     = res_taken ? res_target : res_pc + AWIDTH'(4);
    assign mispredict = pop && (head_tgt != actual);

    // Sequencing faults only count while the unit is listening (IDLE).
    assign seq_err = in_idle && ((pred_valid && full) || (res_valid && empty) ||
                                 (pop && (head_pc != res_pc)));

    // Flush is high for every cycle the FSM spends in FLUSH, which is already a register.
    assign flush = (state == FLUSH);

    // FSM state register and flush cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            state <= state_d;
            fcnt  <= fcnt_d;
        end
    end

    // Next-state logic: a mispredict enters FLUSH, which lasts FLUSH_CYC cycles.
    always_comb begin
        state_d = state;
        fcnt_d  = fcnt;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    fcnt_d  = FCW'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (fcnt == '0) state_d = IDLE;
                else            fcnt_d  = fcnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue pointers; a mispredict discards every younger (wrong-path) entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (mispredict) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Queue storage is pure data; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr[IW-1:0]]  <= pred_pc;
            q_tgt[wr_ptr[IW-1:0]] <= pred_target;
        end
    end

    // Registered outputs: BTB update, redirect, statistics and sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_en         <= 1'b0;
            upd_pc         <= '0;
            upd_target     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
            err_seq        <= 1'b0;
        end else begin
            upd_en         <= pop && res_taken;
            redirect_valid <= mispredict;
            if (pop) begin
                upd_pc     <= res_pc;
                upd_target <= res_target;
                branch_cnt <= sat_inc(branch_cnt);
            end
            if (mispredict) begin
                redirect_pc <= actual;
                mispred_cnt <= sat_inc(mispred_cnt);
            end
            if (seq_err) err_seq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: table-driven resolve vectors plus
// hand-written sequences for flush, queue-full, empty-resolve, async reset and
// counter saturation. Expected outputs come from a small behavioural model.
module tb_branch_resolve_unit;

    localparam int AW = 32;
    localparam int QD = 4;
    localparam int FC = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pred_valid = 1'b0;
    logic [AW-1:0] pred_pc = '0, pred_target = '0;
    logic          pred_ready;
    logic          res_valid = 1'b0;
    logic [AW-1:0] res_pc = '0;
    logic          res_taken = 1'b0;
    logic [AW-1:0] res_target = '0;
    logic          upd_en;
    logic [AW-1:0] upd_pc, upd_target;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          flush;
    logic [CW-1:0] branch_cnt, mispred_cnt;
    logic          err_seq;

    branch_resolve_unit #(.AWIDTH(AW), .QDEPTH(QD), .FLUSH_CYC(FC), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target),
        .pred_ready(pred_ready),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
        .res_target(res_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
        .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [AW-1:0] tgt;
    } pred_t;

    typedef struct packed {
        logic          upd_en;
        logic [AW-1:0] upd_pc;
        logic [AW-1:0] upd_tgt;
        logic          redir;
        logic [AW-1:0] rpc;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] ptgt;
        logic          taken;
        logic [AW-1:0] rtgt;
        logic          mis;
        logic [AW-1:0] rpc_exp;
    } vec_t;

    pred_t         mq[$];
    exp_t          sb[$];
    logic [CW-1:0] m_bc = '0, m_mc = '0;
    logic          m_err = 1'b0;
    logic          hold_flush = 1'b0;
    int            nchk = 0, nfail = 0;
    vec_t          tbl[5];

    function automatic logic [CW-1:0] msat(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        mq.delete();
        sb.delete();
        m_bc = '0;
        m_mc = '0;
        m_err = 1'b0;
        rst = 1'b1;
    endtask

    task automatic wait_flush();
        check("flush_c1", flush, 1'b1);
        step();
        check("flush_c2", flush, 1'b1);
        check("redir_c2", redirect_valid, 1'b0);
        check("ready_in_flush", pred_ready, 1'b0);
        step();
        check("flush_end", flush, 1'b0);
        check("ready_after_flush", pred_ready, 1'b1);
    endtask

    // One clock of stimulus; the model predicts, the scoreboard carries expectations.
    task automatic cycle(input logic pv, input logic [AW-1:0] ppc, input logic [AW-1:0] ptgt,
                         input logic rv, input logic [AW-1:0] rpc, input logic rt,
                         input logic [AW-1:0] rtg, output logic mis);
        pred_t         h;
        exp_t          e;
        logic          ap, ar;
        logic [AW-1:0] act;
        ap  = pv && (mq.size() < QD);
        ar  = rv && (mq.size() > 0);
        mis = 1'b0;
        if (pv && !ap) m_err = 1'b1;
        if (rv && !ar) m_err = 1'b1;
        if (ar) begin
            h   = mq.pop_front();
            act = rt ? rtg : rpc + 32'd4;
            mis = (h.tgt != act);
            if (h.pc != rpc) m_err = 1'b1;
            m_bc = msat(m_bc);
            if (mis) m_mc = msat(m_mc);
            e = '{upd_en: rt, upd_pc: rpc, upd_tgt: rtg, redir: mis, rpc: act, bc: m_bc, mc: m_mc};
            sb.push_back(e);
        end
        if (ap) mq.push_back('{pc: ppc, tgt: ptgt});
        if (mis) mq.delete();

        pred_valid = pv; pred_pc = ppc; pred_target = ptgt;
        res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtg;
        step();
        pred_valid = 1'b0;
        res_valid  = 1'b0;

        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("upd_en", upd_en, e.upd_en);
            check("upd_pc", upd_pc, e.upd_pc);
            check("upd_target", upd_target, e.upd_tgt);
            check("redirect_valid", redirect_valid, e.redir);
            if (e.redir) check("redirect_pc", redirect_pc, e.rpc);
            check("branch_cnt", branch_cnt, e.bc);
            check("mispred_cnt", mispred_cnt, e.mc);
        end else begin
            check("upd_en_idle", upd_en, 1'b0);
            check("redir_idle", redirect_valid, 1'b0);
            check("branch_cnt_hold", branch_cnt, m_bc);
            check("mispred_cnt_hold", mispred_cnt, m_mc);
        end
        check("err_seq", err_seq, m_err);
        if (!mis) check("pred_ready", pred_ready, mq.size() < QD);
        if (mis && !hold_flush) wait_flush();
    endtask

    logic mis;

    initial begin
        tbl[0] = '{pc: 32'h100, ptgt: 32'h104, taken: 1'b0, rtgt: 32'h0,   mis: 1'b0, rpc_exp: 32'h0};
        tbl[1] = '{pc: 32'h400, ptgt: 32'h480, taken: 1'b1, rtgt: 32'h480, mis: 1'b0, rpc_exp: 32'h0};
        tbl[2] = '{pc: 32'h500, ptgt: 32'h504, taken: 1'b1, rtgt: 32'h600, mis: 1'b1, rpc_exp: 32'h600};
        tbl[3] = '{pc: 32'h700, ptgt: 32'h780, taken: 1'b0, rtgt: 32'h780, mis: 1'b1, rpc_exp: 32'h704};
        tbl[4] = '{pc: 32'hFFFF_FFFC, ptgt: 32'h0, taken: 1'b0, rtgt: 32'h40, mis: 1'b0, rpc_exp: 32'h0};

        // Reset state
        #3;
        check("rst_flush", flush, 1'b0);
        check("rst_redirect", redirect_valid, 1'b0);
        check("rst_upd_en", upd_en, 1'b0);
        check("rst_branch_cnt", branch_cnt, 0);
        check("rst_mispred_cnt", mispred_cnt, 0);
        check("rst_err", err_seq, 1'b0);
        check("rst_ready", pred_ready, 1'b1);
        rst = 1'b1;
        step();

        // Table-driven push/resolve pairs
        hold_flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, tbl[i].pc, tbl[i].ptgt, 1'b0, '0, 1'b0, '0, mis);
            cycle(1'b0, '0, '0, 1'b1, tbl[i].pc, tbl[i].taken, tbl[i].rtgt, mis);
            check("tbl_redirect", redirect_valid, tbl[i].mis);
            if (tbl[i].mis) begin
                check("tbl_redirect_pc", redirect_pc, tbl[i].rpc_exp);
                wait_flush();
            end
        end
        hold_flush = 1'b0;

        // Mispredict clears younger entries; then resolve on an empty queue
        cycle(1'b1, 32'h200, 32'h204, 1'b0, '0, 1'b0, '0, mis);
        cycle(1'b1, 32'h208, 32'h20C, 1'b0, '0, 1'b0, '0, mis);
        cycle(1'b0, '0, '0, 1'b1, 32'h200, 1'b1, 32'h300, mis);
        check("err_before_empty", err_seq, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 32'h208, 1'b0, '0, mis);
        check("err_empty_res", err_seq, 1'b1);

        // Fill, overflow push, simultaneous push+pop at three entries
        do_reset();
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 32'(i * 16), 32'(i * 16 + 4), 1'b0, '0, 1'b0, '0, mis);
        check("full_ready", pred_ready, 1'b0);
        check("full_no_err", err_seq, 1'b0);
        cycle(1'b1, 32'h99, 32'h9D, 1'b0, '0, 1'b0, '0, mis);
        check("overflow_err", err_seq, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 32'h10, 1'b0, '0, mis);
        cycle(1'b1, 32'h50, 32'h54, 1'b1, 32'h20, 1'b0, '0, mis);
        check("pushpop_ready", pred_ready, 1'b1);
        cycle(1'b1, 32'h60, 32'h64, 1'b0, '0, 1'b0, '0, mis);
        check("refill_ready", pred_ready, 1'b0);
        for (int i = 3; i <= 6; i++)
            cycle(1'b0, '0, '0, 1'b1, 32'(i * 16), 1'b0, '0, mis);

        // Asynchronous reset during the first flush cycle
        do_reset();
        hold_flush = 1'b1;
        cycle(1'b1, 32'h900, 32'h904, 1'b0, '0, 1'b0, '0, mis);
        cycle(1'b0, '0, '0, 1'b1, 32'h900, 1'b1, 32'hA00, mis);
        check("pre_rst_flush", flush, 1'b1);
        rst = 1'b0;
        #1;
        check("arst_flush", flush, 1'b0);
        check("arst_redirect", redirect_valid, 1'b0);
        check("arst_branch_cnt", branch_cnt, 0);
        check("arst_mispred_cnt", mispred_cnt, 0);
        check("arst_ready", pred_ready, 1'b1);
        mq.delete();
        m_bc = '0;
        m_mc = '0;
        m_err = 1'b0;
        rst = 1'b1;
        hold_flush = 1'b0;
        cycle(1'b0, '0, '0, 1'b1, 32'h900, 1'b0, '0, mis);

        // Mispredict counter saturation at 15
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'h1000 + 32'(i * 8), 32'h1004 + 32'(i * 8), 1'b0, '0, 1'b0, '0, mis);
            cycle(1'b0, '0, '0, 1'b1, 32'h1000 + 32'(i * 8), 1'b1, 32'h2000, mis);
        end
        check("sat_mispred", mispred_cnt, 4'd15);
        check("sat_branch", branch_cnt, 4'd15);

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

endmodule
